// File: rtl/dth_sensor_emu_if.sv
// dth_sensor_emu_if: line, data and status signals between a host-side driver and the DHT sensor emulator
interface dth_sensor_emu_if;
    logic        dth_i;
    logic        dth_oe_o;
    logic [31:0] data_i;
    logic        load_i;
    logic        bad_sum_i;
    logic        busy_o;
    logic        frame_done_o;
    logic [7:0]  start_cnt_o;
    modport master (
        output dth_i, data_i, load_i, bad_sum_i,
        input  dth_oe_o, busy_o, frame_done_o, start_cnt_o
    );
    modport slave (
        input  dth_i, data_i, load_i, bad_sum_i,
        output dth_oe_o, busy_o, frame_done_o, start_cnt_o
    );
endinterface

// File: rtl/dth_sensor_emu.sv
// dth_sensor_emu: sensor end of the DHT single-wire protocol; answers a host start pulse with preamble, data and checksum
module dth_sensor_emu #(
    parameter int unsigned CLK_MHZ       = 100,
    parameter int unsigned START_MIN_US  = 1000,
    parameter int unsigned RESP_DELAY_US = 30,
    parameter int unsigned RESP_LOW_US   = 80,
    parameter int unsigned RESP_HIGH_US  = 80,
    parameter int unsigned BIT_LOW_US    = 50,
    parameter int unsigned BIT0_HIGH_US  = 26,
    parameter int unsigned BIT1_HIGH_US  = 70,
    parameter int unsigned END_LOW_US    = 50
) (
    input logic             clk,
    input logic             rst,
    dth_sensor_emu_if.slave bus
);
    localparam int unsigned ST_C = START_MIN_US * CLK_MHZ;
    localparam int unsigned RD_C = RESP_DELAY_US * CLK_MHZ;
    localparam int unsigned RL_C = RESP_LOW_US * CLK_MHZ;
    localparam int unsigned RH_C = RESP_HIGH_US * CLK_MHZ;
    localparam int unsigned BL_C = BIT_LOW_US * CLK_MHZ;
    localparam int unsigned B0_C = BIT0_HIGH_US * CLK_MHZ;
    localparam int unsigned B1_C = BIT1_HIGH_US * CLK_MHZ;
    localparam int unsigned EL_C = END_LOW_US * CLK_MHZ;
    localparam int CW = $clog2(ST_C + RD_C + RL_C + RH_C + BL_C + B0_C + B1_C + EL_C + 2);
    typedef enum logic [2:0] {IDLE, HOST_LOW, RESP_DELAY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, END_LOW} state_t;
    state_t        state;
    logic          s1, s_dth, armed, tick, long_ok;
    logic [CW-1:0] cnt, dur;
    logic [31:0]   hold, sh;
    logic [39:0]   frame;
    logic [5:0]    idx;
    logic [7:0]    sum;
    always_comb begin
        sh      = bus.load_i ? bus.data_i : hold;
        sum     = sh[31:24] + sh[23:16] + sh[15:8] + sh[7:0];
        dur     = state == RESP_DELAY ? CW'(RD_C) :
                  state == RESP_LOW   ? CW'(RL_C) :
                  state == RESP_HIGH  ? CW'(RH_C) :
                  state == BIT_LOW    ? CW'(BL_C) :
                  state == BIT_HIGH   ? (frame[idx] ? CW'(B1_C) : CW'(B0_C)) : CW'(EL_C);
        tick    = cnt == dur - 1'b1;
        long_ok = cnt >= CW'(ST_C - 1);
    end
    // The IDLE cycle that first sees the low counts toward the host low time, hence the threshold of ST_C-1.
    // armed blocks a host low that outlasts the frame from re-triggering until the line is seen high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            s1               <= 1'b1;
            s_dth            <= 1'b1;
            armed            <= 1'b0;
            hold             <= '0;
            frame            <= '0;
            idx              <= '0;
            bus.dth_oe_o     <= 1'b0;
            bus.busy_o       <= 1'b0;
            bus.frame_done_o <= 1'b0;
            bus.start_cnt_o  <= '0;
        end else begin
            s1               <= bus.dth_i;
            s_dth            <= s1;
            hold             <= sh;
            bus.frame_done_o <= 1'b0;
            cnt              <= &cnt ? cnt : cnt + 1'b1;
            case (state)
                IDLE: begin
                    armed <= armed | s_dth;
                    if (!s_dth && armed) begin
                        state <= HOST_LOW;
                        cnt   <= '0;
                    end
                end
                HOST_LOW: if (s_dth) begin
                    cnt   <= '0;
                    state <= long_ok ? RESP_DELAY : IDLE;
                    if (long_ok) begin
                        bus.busy_o      <= 1'b1;
                        bus.start_cnt_o <= bus.start_cnt_o + 8'd1;
                        frame           <= {sh, sum ^ {7'd0, bus.bad_sum_i}};
                    end
                end
                RESP_DELAY: if (tick) begin
                    state        <= RESP_LOW;
                    cnt          <= '0;
                    bus.dth_oe_o <= 1'b1;
                end
                RESP_LOW: if (tick) begin
                    state        <= RESP_HIGH;
                    cnt          <= '0;
                    bus.dth_oe_o <= 1'b0;
                end
                RESP_HIGH: if (tick) begin
                    state        <= BIT_LOW;
                    cnt          <= '0;
                    idx          <= 6'd39;
                    bus.dth_oe_o <= 1'b1;
                end
                BIT_LOW: if (tick) begin
                    state        <= BIT_HIGH;
                    cnt          <= '0;
                    bus.dth_oe_o <= 1'b0;
                end
                BIT_HIGH: if (tick) begin
                    state        <= idx == 6'd0 ? END_LOW : BIT_LOW;
                    cnt          <= '0;
                    idx          <= idx - 6'd1;
                    bus.dth_oe_o <= 1'b1;
                end
                END_LOW: if (tick) begin
                    state            <= IDLE;
                    cnt              <= '0;
                    armed            <= 1'b0;
                    bus.dth_oe_o     <= 1'b0;
                    bus.busy_o       <= 1'b0;
                    bus.frame_done_o <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: doc/dth_sensor_emu.md
Name: dth_sensor_emu

Overview:
- Cycle-accurate emulator of the sensor end of the DHT single-wire protocol. It responds to a host start pulse with the response preamble and a 40-bit frame plus checksum.
- It sits on the FPGA opposite the existing DTH host reader, either looped back or on a second pin. This lets the reader and the BCD/display path be exercised without a physical sensor.
- Drive is open-drain: the block only ever pulls the line low or releases it.

Parameters:
CLK_MHZ, 100, clock frequency in MHz; every time below is converted to cycles as US*CLK_MHZ
START_MIN_US, 1000, minimum host low time accepted as a start request
RESP_DELAY_US, 30, wait after host release before the response begins
RESP_LOW_US, 80, response low time
RESP_HIGH_US, 80, response high time
BIT_LOW_US, 50, low slot preceding every data bit
BIT0_HIGH_US, 26, high time encoding a 0
BIT1_HIGH_US, 70, high time encoding a 1
END_LOW_US, 50, trailing low after bit 0 of the frame

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
dth_i  in  1  sampled level of the shared data line (asynchronous; synchronised inside)
dth_oe_o  out  1  1 = pull the line low, 0 = release it (top level ties the pad as oe ? 1'b0 : 1'bz)
data_i  in  32  {hum_int, hum_dec, temp_int, temp_dec}
load_i  in  1  1-cycle strobe: copy data_i into the holding register
bad_sum_i  in  1  when 1 at frame start, transmitted checksum is XORed with 8'h01
busy_o  out  1  1 from start-request acceptance until the frame ends
frame_done_o  out  1  1-cycle pulse when the line is released after END_LOW
start_cnt_o  out  8  count of accepted start requests, wraps 255->0

Behaviour:
- Reset (any state): the following take effect on the next edge.
  - dth_oe_o=0, busy_o=0, frame_done_o=0, start_cnt_o=0.
  - Holding register = 32'h0; FSM goes to IDLE; sync flops are set to 1.
  - The line is released on that edge even if reset arrives mid-frame.
- Input sync: two flops; all FSM decisions use the second flop (s_dth). The sync adds 2 cycles of latency to host-edge detection.
- Holding register: loaded on load_i in any state. The frame sends a shadow copy latched on entry to RESP_DELAY, so a load_i during a frame never tears the frame.
- Checksum: sum of the four data bytes mod 256, XOR 8'h01 if bad_sum_i is sampled on entry to RESP_DELAY.
- Frame order: {data[31:0], checksum}, MSB (bit 39) first.
- Single cycle counter: reset on every state entry; saturates at all-ones and never wraps.
- FSM states:
  - IDLE: dth_oe_o=0. s_dth==0 -> HOST_LOW.
  - HOST_LOW: count cycles while s_dth==0.
    - s_dth==1 with count >= START_MIN_US*CLK_MHZ -> RESP_DELAY; busy_o=1; start_cnt_o++.
    - s_dth==1 with count shorter -> IDLE (glitch ignored; no counter increment).
  - RESP_DELAY: line released for RESP_DELAY cycles, then -> RESP_LOW.
  - RESP_LOW: dth_oe_o=1 for RESP_LOW cycles, then -> RESP_HIGH.
  - RESP_HIGH: released for RESP_HIGH cycles; bit index := 39; then -> BIT_LOW.
  - BIT_LOW: dth_oe_o=1 for BIT_LOW cycles, then -> BIT_HIGH.
  - BIT_HIGH: released for BIT0_HIGH or BIT1_HIGH cycles according to frame[index].
    - index==0 -> END_LOW.
    - otherwise index-- and -> BIT_LOW.
  - END_LOW: dth_oe_o=1 for END_LOW cycles, then -> IDLE; busy_o=0; frame_done_o=1 for one cycle.
- Each timed state lasts exactly its programmed cycle count.
- dth_oe_o is registered; it changes on the same edge as the state change.
- The line level is ignored outside IDLE and HOST_LOW; host contention during a frame does not abort the frame.
- A host low that persists after the frame ends is treated as a new request only after it is first seen high in IDLE. IDLE requires s_dth==1 for at least 1 cycle before HOST_LOW can be entered again.
- Simultaneous load_i and frame-start latch: the shadow takes the value being loaded that cycle (data_i).

Test Plan:
- Reset mid-frame (CLK_MHZ=1): assert rst during BIT_LOW -> dth_oe_o=0 on the next edge, busy_o=0, start_cnt_o=0; the next host pulse produces a full, correct frame.
- Basic frame (CLK_MHZ=1): load data_i=32'h3700_1A05, then host low 1000 cycles and release.
  - Response: 30 released, 80 low, 80 high.
  - 40 bits carry 0x37,0x00,0x1A,0x05,0x56; '0' high = 26 cycles, '1' high = 70 cycles.
  - Then 50 low; frame_done_o pulses once; start_cnt_o=1.
- Short start: host low 999 cycles (CLK_MHZ=1) -> no drive, busy_o stays 0, start_cnt_o unchanged.
- Checksum wrap and corruption: data 32'hFF_FF_FF_FF -> checksum 0xFC; repeat with bad_sum_i=1 -> 0xFD.
- Mid-frame load: load_i with 32'h1111_1111 during bit 20 -> current frame unchanged; the next frame carries 0x11 bytes and checksum 0x44.
- Loopback with the DTH host reader, default parameters: the reader's DHT_data_ready asserts, its error stays 0, and DTH_data equals the loaded 32-bit data followed by the correct checksum byte.
